// File: rtl/forward_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: forwarding source select and pending-slot record.
// The slot record carries a destination of FS_REG_ADDR_W bits, so REG_ADDR_W must stay equal to it.
package forward_scoreboard_pkg;

   localparam int FS_REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_NONE,
      FWD_BYPASS,
      FWD_STAGE,
      FWD_HAZARD
   } fwdSrc_e;

   typedef struct packed {
      logic                     valid;
      logic                     live;
      logic [FS_REG_ADDR_W-1:0] destReg;
   } pendingSlot_t;

   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/forward_scoreboard_pending_table.sv
// Pending table for long-latency writers: lowest-free-slot allocator, WAW live clearing, completion free.
// Allocation is judged on start-of-cycle state, so a slot freed this cycle is only reusable next cycle.
module forward_scoreboard_pending_table
   import forward_scoreboard_pkg::*;
#(
   parameter int REG_ADDR_W  = FS_REG_ADDR_W,
   parameter int MAX_PENDING = 4,
   parameter int TAG_W       = tag_width(MAX_PENDING)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 issue_valid_i,
   input  logic [REG_ADDR_W-1:0]                issue_reg_i,
   output logic                                 issue_ready_o,
   output logic [TAG_W-1:0]                     issue_tag_o,
   output logic                                 issue_accept_o,
   input  logic                                 complete_valid_i,
   input  logic [TAG_W-1:0]                     complete_tag_i,
   output pendingSlot_t [MAX_PENDING-1:0]       slots_o
);

   pendingSlot_t [MAX_PENDING-1:0] slots_q, slots_d;
   logic                           free_found;
   logic [TAG_W-1:0]               free_tag;

   // Scan downwards so the lowest free index is the one left standing.
   always_comb begin
      free_found = 1'b0;
      free_tag   = '0;
      for (int i = MAX_PENDING - 1; i >= 0; i--) begin
         if (!slots_q[i].valid) begin
            free_found = 1'b1;
            free_tag   = TAG_W'(i);
         end
      end
   end

   assign issue_ready_o  = free_found;
   assign issue_tag_o    = free_tag;
   assign issue_accept_o = issue_valid_i && free_found && (issue_reg_i != '0);

   always_comb begin
      // NOTE: slots_d starts as a copy of slots_q so every path assigns it and no latch is inferred.
      slots_d = slots_q;
      for (int i = 0; i < MAX_PENDING; i++) begin
         if (complete_valid_i && (complete_tag_i == TAG_W'(i)) && slots_q[i].valid) begin
            slots_d[i] = '0;
         end
      end
      if (issue_accept_o) begin
         for (int i = 0; i < MAX_PENDING; i++) begin
            if (slots_q[i].valid && slots_q[i].live && (slots_q[i].destReg == issue_reg_i)) begin
               slots_d[i].live = 1'b0;
            end
         end
         for (int i = 0; i < MAX_PENDING; i++) begin
            if (free_tag == TAG_W'(i)) begin
               slots_d[i] = '{valid: 1'b1, live: 1'b1, destReg: issue_reg_i};
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (reset) begin
         slots_q <= '0;
      end else begin
         slots_q <= slots_d;
      end
   end

   assign slots_o = slots_q;

endmodule

// File: rtl/forward_scoreboard.sv
// Operand forwarding scoreboard: per-port bypass / stage / pending-hazard resolution plus stall request.
// Optional stall counter output stallCount is built when FORWARD_SCOREBOARD_PERF_EN is defined.
module forward_scoreboard
   import forward_scoreboard_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_W     = FS_REG_ADDR_W,
   parameter int NUM_READ_PORTS = 2,
   parameter int NUM_FWD_STAGES = 2,
   parameter int MAX_PENDING    = 4,
   localparam int TAG_W         = tag_width(MAX_PENDING)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] readReg,
   input  logic [NUM_FWD_STAGES-1:0]            stageValid,
   input  logic [NUM_FWD_STAGES-1:0]            stageWriteEnable,
   input  logic [NUM_FWD_STAGES-1:0]            stageDataReady,
   input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stageDestReg,
   input  logic [NUM_FWD_STAGES*XLEN-1:0]       stageData,
   input  logic                                 issueValid,
   input  logic [REG_ADDR_W-1:0]                issueReg,
   output logic                                 issueReady,
   output logic [TAG_W-1:0]                     issueTag,
   input  logic                                 completeValid,
   input  logic [TAG_W-1:0]                     completeTag,
   input  logic [XLEN-1:0]                      completeData,
   output logic [NUM_READ_PORTS-1:0]            fwdEnable,
   output logic [NUM_READ_PORTS*XLEN-1:0]       fwdData,
   output logic                                 stallReq
`ifdef FORWARD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]                          stallCount
`endif
);

   pendingSlot_t [MAX_PENDING-1:0] slots;
   logic                           issue_accept;
   logic [NUM_READ_PORTS-1:0]      port_hazard;

   forward_scoreboard_pending_table #(
      .REG_ADDR_W  (REG_ADDR_W),
      .MAX_PENDING (MAX_PENDING),
      .TAG_W       (TAG_W)
   ) u_pending_table (
      .clk              (clk),
      .reset            (reset),
      .issue_valid_i    (issueValid),
      .issue_reg_i      (issueReg),
      .issue_ready_o    (issueReady),
      .issue_tag_o      (issueTag),
      .issue_accept_o   (issue_accept),
      .complete_valid_i (completeValid),
      .complete_tag_i   (completeTag),
      .slots_o          (slots)
   );

   always_comb begin
      fwdEnable   = '0;
      fwdData     = '0;
      port_hazard = '0;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         logic [REG_ADDR_W-1:0] rr;
         logic [REG_ADDR_W-1:0] sdest;
         fwdSrc_e               src;
         logic [XLEN-1:0]       data;
         logic                  stage_hit;
         rr        = readReg[p*REG_ADDR_W +: REG_ADDR_W];
         sdest     = '0;
         src       = FWD_NONE;
         data      = '0;
         stage_hit = 1'b0;
         if (rr != '0) begin
            // A same-cycle issue to this register supersedes the returning result.
            for (int i = 0; i < MAX_PENDING; i++) begin
               if (completeValid && (completeTag == TAG_W'(i)) && slots[i].valid && slots[i].live &&
                   (slots[i].destReg == rr) && !(issue_accept && (issueReg == rr))) begin
                  src  = FWD_BYPASS;
                  data = completeData;
               end
            end
            if (src == FWD_NONE) begin
               for (int s = 0; s < NUM_FWD_STAGES; s++) begin
                  sdest = stageDestReg[s*REG_ADDR_W +: REG_ADDR_W];
                  if (!stage_hit && stageValid[s] && stageWriteEnable[s] && (sdest == rr)) begin
                     stage_hit = 1'b1;
                     if (stageDataReady[s]) begin
                        src  = FWD_STAGE;
                        data = stageData[s*XLEN +: XLEN];
                     end else begin
                        src = FWD_HAZARD;
                     end
                  end
               end
            end
            if (src == FWD_NONE) begin
               for (int i = 0; i < MAX_PENDING; i++) begin
                  if (slots[i].valid && slots[i].live && (slots[i].destReg == rr)) begin
                     src = FWD_HAZARD;
                  end
               end
            end
         end
         fwdEnable[p]              = (src == FWD_BYPASS) || (src == FWD_STAGE);
         fwdData[p*XLEN +: XLEN]   = data;
         port_hazard[p]            = (src == FWD_HAZARD);
      end
   end

   assign stallReq = |port_hazard;

`ifdef FORWARD_SCOREBOARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stallReq && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios plus random traffic against a tag/latest-writer model.
// Also checks stallCount when FORWARD_SCOREBOARD_PERF_EN is defined.
module tb_forward_scoreboard;

   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int NP   = 2;
   localparam int NS   = 2;
   localparam int MP   = 4;
   localparam int TW   = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NP*RW-1:0]  readReg;
   logic [NS-1:0]     stageValid, stageWriteEnable, stageDataReady;
   logic [NS*RW-1:0]  stageDestReg;
   logic [NS*XLEN-1:0] stageData;
   logic              issueValid;
   logic [RW-1:0]     issueReg;
   logic              issueReady;
   logic [TW-1:0]     issueTag;
   logic              completeValid;
   logic [TW-1:0]     completeTag;
   logic [XLEN-1:0]   completeData;
   logic [NP-1:0]     fwdEnable;
   logic [NP*XLEN-1:0] fwdData;
   logic              stallReq;
`ifdef FORWARD_SCOREBOARD_PERF_EN
   logic [31:0]       stallCount;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: outstanding tags with their destination, and the newest outstanding writer per register.
   bit              m_busy   [MP];
   logic [RW-1:0]   m_dest   [MP];
   int              m_latest [32];
   logic [31:0]     m_stall_count;

   forward_scoreboard dut (
      .clk              (clk),
      .reset            (reset),
      .readReg          (readReg),
      .stageValid       (stageValid),
      .stageWriteEnable (stageWriteEnable),
      .stageDataReady   (stageDataReady),
      .stageDestReg     (stageDestReg),
      .stageData        (stageData),
      .issueValid       (issueValid),
      .issueReg         (issueReg),
      .issueReady       (issueReady),
      .issueTag         (issueTag),
      .completeValid    (completeValid),
      .completeTag      (completeTag),
      .completeData     (completeData),
      .fwdEnable        (fwdEnable),
      .fwdData          (fwdData),
      .stallReq         (stallReq)
`ifdef FORWARD_SCOREBOARD_PERF_EN
      ,
      .stallCount       (stallCount)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   function automatic int m_free_tag();
      for (int t = 0; t < MP; t++) if (!m_busy[t]) return t;
      return -1;
   endfunction

   function automatic bit m_live(input int t);
      return m_busy[t] && (m_latest[m_dest[t]] == t);
   endfunction

   function automatic bit m_accept();
      return issueValid && (m_free_tag() >= 0) && (issueReg != '0);
   endfunction

   function automatic void model_port(input int p, output bit en, output logic [XLEN-1:0] d, output bit haz);
      logic [RW-1:0] rr;
      logic [RW-1:0] sd;
      int            ct;
      rr  = readReg[p*RW +: RW];
      en  = 1'b0;
      d   = '0;
      haz = 1'b0;
      ct  = int'(completeTag);
      if (rr == '0) return;
      if (completeValid && m_live(ct) && (m_dest[ct] == rr) && !(m_accept() && issueReg == rr)) begin
         en = 1'b1;
         d  = completeData;
         return;
      end
      for (int s = 0; s < NS; s++) begin
         sd = stageDestReg[s*RW +: RW];
         if (stageValid[s] && stageWriteEnable[s] && sd != '0 && sd == rr) begin
            if (stageDataReady[s]) begin
               en = 1'b1;
               d  = stageData[s*XLEN +: XLEN];
            end else begin
               haz = 1'b1;
            end
            return;
         end
      end
      for (int t = 0; t < MP; t++) if (m_live(t) && m_dest[t] == rr) haz = 1'b1;
   endfunction

   task automatic clear_inputs();
      readReg = '0; stageValid = '0; stageWriteEnable = '0; stageDataReady = '0;
      stageDestReg = '0; stageData = '0; issueValid = 1'b0; issueReg = '0;
      completeValid = 1'b0; completeTag = '0; completeData = '0;
   endtask

   task automatic set_read(input int p, input logic [RW-1:0] r);
      readReg[p*RW +: RW] = r;
   endtask

   task automatic set_stage(input int s, input bit v, input bit we, input bit rdy,
                            input logic [RW-1:0] d, input logic [XLEN-1:0] data);
      stageValid[s] = v; stageWriteEnable[s] = we; stageDataReady[s] = rdy;
      stageDestReg[s*RW +: RW] = d; stageData[s*XLEN +: XLEN] = data;
   endtask

   // Advance one clock edge, updating the model from the inputs present before the edge.
   task automatic tick();
      bit stall_exp, en, haz;
      logic [XLEN-1:0] d;
      int ft, ct;
      bit acc;
      stall_exp = 1'b0;
      for (int p = 0; p < NP; p++) begin
         model_port(p, en, d, haz);
         stall_exp |= haz;
      end
      if (reset) begin
         for (int t = 0; t < MP; t++) m_busy[t] = 1'b0;
         for (int r = 0; r < 32; r++) m_latest[r] = -1;
         m_stall_count = '0;
      end else begin
         ft  = m_free_tag();
         acc = m_accept();
         ct  = int'(completeTag);
         if (stall_exp && m_stall_count != 32'hFFFF_FFFF) m_stall_count++;
         if (completeValid && m_busy[ct]) begin
            m_busy[ct] = 1'b0;
            if (m_latest[m_dest[ct]] == ct) m_latest[m_dest[ct]] = -1;
         end
         if (acc) begin
            m_busy[ft]         = 1'b1;
            m_dest[ft]         = issueReg;
            m_latest[issueReg] = ft;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++; if (issueReady !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", issueReady); end
      tests_run++; if (issueTag !== 2'd0) begin tests_failed++; $display("FAIL reset_tag: got %0d want 0", issueTag); end
      tests_run++; if (fwdEnable !== 2'b00) begin tests_failed++; $display("FAIL reset_fwd_en: got %b want 00", fwdEnable); end
      tests_run++; if (fwdData !== '0) begin tests_failed++; $display("FAIL reset_fwd_data: got %h want 0", fwdData); end
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stallReq); end
`ifdef FORWARD_SCOREBOARD_PERF_EN
      tests_run++; if (stallCount !== 32'd0) begin tests_failed++; $display("FAIL reset_stall_count: got %0d want 0", stallCount); end
`endif
   endtask

   task automatic test_stage_priority();
      do_reset();
      set_stage(0, 1, 1, 1, 5'd5, 32'h11);
      set_stage(1, 1, 1, 1, 5'd5, 32'h22);
      set_read(0, 5'd5);
      #1;
      tests_run++; if (fwdEnable[0] !== 1'b1) begin tests_failed++; $display("FAIL stage_young_en: got %b want 1", fwdEnable[0]); end
      tests_run++; if (fwdData[31:0] !== 32'h11) begin tests_failed++; $display("FAIL stage_young_data: got %h want 11", fwdData[31:0]); end
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL stage_young_stall: got %b want 0", stallReq); end
      set_stage(0, 1, 0, 1, 5'd5, 32'h11);
      #1;
      tests_run++; if (fwdData[31:0] !== 32'h22) begin tests_failed++; $display("FAIL stage_old_data: got %h want 22", fwdData[31:0]); end
      set_stage(0, 1, 1, 1, 5'd0, 32'h11);
      set_stage(1, 1, 1, 1, 5'd0, 32'h22);
      set_read(0, 5'd0);
      set_read(1, 5'd0);
      #1;
      tests_run++; if (fwdEnable !== 2'b00) begin tests_failed++; $display("FAIL stage_reg0_en: got %b want 00", fwdEnable); end
      tick();
   endtask

   task automatic test_stage_not_ready();
      do_reset();
      set_stage(0, 1, 1, 0, 5'd7, 32'h0);
      set_stage(1, 1, 1, 1, 5'd7, 32'h33);
      set_read(1, 5'd7);
      #1;
      tests_run++; if (fwdEnable[1] !== 1'b0) begin tests_failed++; $display("FAIL notready_en: got %b want 0", fwdEnable[1]); end
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL notready_stall: got %b want 1", stallReq); end
      tick();
   endtask

   task automatic test_bypass();
      do_reset();
      issueValid = 1'b1; issueReg = 5'd9;
      #1;
      tests_run++; if (issueTag !== 2'd0) begin tests_failed++; $display("FAIL bypass_tag: got %0d want 0", issueTag); end
      tick();
      issueValid = 1'b0;
      set_read(0, 5'd9);
      #1;
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL bypass_pending_stall: got %b want 1", stallReq); end
      completeValid = 1'b1; completeTag = 2'd0; completeData = 32'hABCD;
      #1;
      tests_run++; if (fwdEnable[0] !== 1'b1) begin tests_failed++; $display("FAIL bypass_en: got %b want 1", fwdEnable[0]); end
      tests_run++; if (fwdData[31:0] !== 32'hABCD) begin tests_failed++; $display("FAIL bypass_data: got %h want abcd", fwdData[31:0]); end
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL bypass_stall: got %b want 0", stallReq); end
      tick();
      completeValid = 1'b0;
      #1;
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL bypass_after_stall: got %b want 0", stallReq); end
      tests_run++; if (issueReady !== 1'b1 || issueTag !== 2'd0) begin tests_failed++; $display("FAIL bypass_freed: got ready=%b tag=%0d want ready=1 tag=0", issueReady, issueTag); end
   endtask

   task automatic test_alloc_full();
      do_reset();
      for (int k = 0; k < MP; k++) begin
         issueValid = 1'b1; issueReg = RW'(10 + k);
         #1;
         tests_run++; if (issueTag !== TW'(k)) begin tests_failed++; $display("FAIL alloc_tag%0d: got %0d want %0d", k, issueTag, k); end
         tick();
      end
      issueValid = 1'b0;
      #1;
      tests_run++; if (issueReady !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b want 0", issueReady); end
      issueValid = 1'b1; issueReg = 5'd14;
      tick();
      issueValid = 1'b0;
      set_read(0, 5'd14);
      #1;
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL full_issue_ignored: got stall=%b want 0", stallReq); end
      set_read(0, 5'd0);
      completeValid = 1'b1; completeTag = 2'd2; completeData = 32'h5;
      issueValid = 1'b1; issueReg = 5'd15;
      #1;
      tests_run++; if (issueReady !== 1'b0) begin tests_failed++; $display("FAIL freed_same_cycle_ready: got %b want 0", issueReady); end
      tick();
      completeValid = 1'b0; issueValid = 1'b0;
      set_read(0, 5'd15);
      #1;
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL freed_same_cycle_issue: got stall=%b want 0", stallReq); end
      tests_run++; if (issueReady !== 1'b1 || issueTag !== 2'd2) begin tests_failed++; $display("FAIL realloc_tag: got ready=%b tag=%0d want ready=1 tag=2", issueReady, issueTag); end
      issueValid = 1'b1; issueReg = 5'd15;
      tick();
      issueValid = 1'b0;
      #1;
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL realloc_stall: got %b want 1", stallReq); end
      set_read(0, 5'd12);
      #1;
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL completed_reg_stall: got %b want 0", stallReq); end
   endtask

   task automatic test_waw();
      do_reset();
      issueValid = 1'b1; issueReg = 5'd3;
      tick();
      #1;
      tests_run++; if (issueTag !== 2'd1) begin tests_failed++; $display("FAIL waw_tag: got %0d want 1", issueTag); end
      tick();
      issueValid = 1'b0;
      set_read(0, 5'd3);
      completeValid = 1'b1; completeTag = 2'd0; completeData = 32'h1;
      #1;
      tests_run++; if (fwdEnable[0] !== 1'b0) begin tests_failed++; $display("FAIL waw_no_bypass: got %b want 0", fwdEnable[0]); end
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL waw_stall: got %b want 1", stallReq); end
      tick();
      completeValid = 1'b0;
      #1;
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL waw_still_stall: got %b want 1", stallReq); end
      completeValid = 1'b1; completeTag = 2'd1; completeData = 32'h5;
      #1;
      tests_run++; if (fwdEnable[0] !== 1'b1 || fwdData[31:0] !== 32'h5) begin tests_failed++; $display("FAIL waw_bypass: got en=%b data=%h want en=1 data=5", fwdEnable[0], fwdData[31:0]); end
      tick();
      completeValid = 1'b0;
      #1;
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL waw_done_stall: got %b want 0", stallReq); end
      set_read(0, 5'd0);
      issueValid = 1'b1; issueReg = 5'd4;
      tick();
      completeValid = 1'b1; completeTag = 2'd0; completeData = 32'h7;
      tick();
      issueValid = 1'b0; completeValid = 1'b0;
      set_read(0, 5'd4);
      #1;
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL issue_complete_same_reg: got stall=%b want 1", stallReq); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         issueValid = 1'b1; issueReg = RW'(20 + k);
         tick();
      end
      issueValid = 1'b0;
      set_read(0, 5'd21);
      #1;
      tests_run++; if (stallReq !== 1'b1) begin tests_failed++; $display("FAIL midop_stall: got %b want 1", stallReq); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      tests_run++; if (issueReady !== 1'b1 || issueTag !== 2'd0) begin tests_failed++; $display("FAIL midop_reset_alloc: got ready=%b tag=%0d want ready=1 tag=0", issueReady, issueTag); end
      tests_run++; if (stallReq !== 1'b0) begin tests_failed++; $display("FAIL midop_reset_stall: got %b want 0", stallReq); end
      completeValid = 1'b1; completeTag = 2'd1; completeData = 32'h55;
      #1;
      tests_run++; if (fwdEnable[0] !== 1'b0) begin tests_failed++; $display("FAIL stale_complete_bypass: got %b want 0", fwdEnable[0]); end
      tick();
      completeValid = 1'b0;
      #1;
      tests_run++; if (issueTag !== 2'd0 || stallReq !== 1'b0) begin tests_failed++; $display("FAIL stale_complete_table: got tag=%0d stall=%b want tag=0 stall=0", issueTag, stallReq); end
`ifdef FORWARD_SCOREBOARD_PERF_EN
      tests_run++; if (stallCount !== 32'd0) begin tests_failed++; $display("FAIL midop_stall_count: got %0d want 0", stallCount); end
`endif
   endtask

   task automatic test_random();
      bit en, haz, stall_exp, ready_exp;
      logic [XLEN-1:0] d;
      int ft;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) set_read(p, RW'($urandom_range(0, 7)));
         for (int s = 0; s < NS; s++)
            set_stage(s, 1'($urandom), 1'($urandom), 1'($urandom), RW'($urandom_range(0, 7)), $urandom);
         issueValid    = ($urandom_range(0, 9) < 4);
         issueReg      = RW'($urandom_range(0, 7));
         completeValid = ($urandom_range(0, 9) < 4);
         completeTag   = TW'($urandom_range(0, MP - 1));
         completeData  = $urandom;
         reset         = ($urandom_range(0, 79) == 0);
         #1;
         if (!reset) begin
            ft        = m_free_tag();
            ready_exp = (ft >= 0);
            tests_run++; if (issueReady !== ready_exp) begin tests_failed++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, issueReady, ready_exp); end
            if (ready_exp) begin
               tests_run++; if (issueTag !== TW'(ft)) begin tests_failed++; $display("FAIL rnd_tag c=%0d: got %0d want %0d", c, issueTag, ft); end
            end
            stall_exp = 1'b0;
            for (int p = 0; p < NP; p++) begin
               model_port(p, en, d, haz);
               stall_exp |= haz;
               tests_run++; if (fwdEnable[p] !== en) begin tests_failed++; $display("FAIL rnd_en c=%0d p=%0d: got %b want %b", c, p, fwdEnable[p], en); end
               if (en) begin
                  tests_run++; if (fwdData[p*XLEN +: XLEN] !== d) begin tests_failed++; $display("FAIL rnd_data c=%0d p=%0d: got %h want %h", c, p, fwdData[p*XLEN +: XLEN], d); end
               end
            end
            tests_run++; if (stallReq !== stall_exp) begin tests_failed++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stallReq, stall_exp); end
         end
         tick();
      end
      reset = 1'b0;
      clear_inputs();
      #1;
`ifdef FORWARD_SCOREBOARD_PERF_EN
      tests_run++; if (stallCount !== m_stall_count) begin tests_failed++; $display("FAIL rnd_stall_count: got %0d want %0d", stallCount, m_stall_count); end
`endif
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      m_stall_count = '0;
      for (int t = 0; t < MP; t++) begin m_busy[t] = 1'b0; m_dest[t] = '0; end
      for (int r = 0; r < 32; r++) m_latest[r] = -1;
      test_reset();
      test_stage_priority();
      test_stage_not_ready();
      test_bypass();
      test_alloc_full();
      test_waw();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
